alu_issue_stage: RTL and testbench

//  Registered issue stage that feeds the RV32 integer ALU. Decodes OP, OP-IMM, LUI and AUIPC words

---
 rtl/alu_issue_stage.sv | 171 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registered issue stage in front of the RV32 integer ALU.
// Decodes OP / OP-IMM / LUI / AUIPC words into ALU controls and operands,
// flags undecodable words and counts them in a saturating counter.
// A main register plus one skid register lets in_ready come straight from a flop.
// Optional feature macro: ISSUE_BYPASS_EN (writeback forwarding into rs1/rs2 at acceptance).
//
// Handshake: a word moves on the input side when in_valid & in_ready, and on the
// output side when out_valid & out_ready; out_* hold steady while out_valid & ~out_ready,
// and words leave in the order they were accepted.
module alu_issue_stage #(
  parameter int CNT_W = 16,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [31:0]      in_rs1_data,
  input  logic [31:0]      in_rs2_data,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_operand1,
  output logic [31:0]      out_operand2,
  output logic [2:0]       out_func3,
  output logic             out_subsra,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  func3;
    logic        subsra;
    logic [4:0]  rd;
    logic        illegal;
  } entry_t;

  entry_t      dec;
  entry_t      main_q;
  entry_t      skid_q;
  logic        main_valid;
  logic        skid_valid;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] pc32;
  logic        in_fire;

  assign pc32    = 32'(in_pc);
  assign in_fire = in_valid & in_ready;

`ifdef ISSUE_BYPASS_EN
  // Forward the writeback value into a source operand that names the same register.
  always_comb begin
    rs1_val = in_rs1_data;
    rs2_val = in_rs2_data;
    if (wb_valid && (wb_rd != 5'd0) && (wb_rd == in_instr[19:15])) rs1_val = wb_data;
    if (wb_valid && (wb_rd != 5'd0) && (wb_rd == in_instr[24:20])) rs2_val = wb_data;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_rd, wb_data};
  assign rs1_val   = in_rs1_data;
  assign rs2_val   = in_rs2_data;
`endif

  // Decode the incoming word into ALU controls; illegal words leave everything zero.
  always_comb begin
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;
    opc   = in_instr[6:0];
    f3    = in_instr[14:12];
    f7    = in_instr[31:25];
    legal = 1'b0;
    dec   = '0;
    case (opc)
      OPC_OP: begin
        legal = (f7 == 7'd0) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
        if (legal) begin
          dec.op1    = rs1_val;
          dec.op2    = rs2_val;
          dec.func3  = f3;
          dec.subsra = in_instr[30];
        end
      end
      OPC_OP_IMM: begin
        if (f3 == 3'b001)      legal = (f7 == 7'd0);
        else if (f3 == 3'b101) legal = (f7 == 7'd0) || (f7 == F7_ALT);
        else                   legal = 1'b1;
        if (legal) begin
          dec.op1    = rs1_val;
          dec.op2    = {{20{in_instr[31]}}, in_instr[31:20]};
          dec.func3  = f3;
          dec.subsra = (f3 == 3'b101) ? in_instr[30] : 1'b0;
        end
      end
      OPC_LUI: begin
        legal   = 1'b1;
        dec.op1 = 32'd0;
        dec.op2 = {in_instr[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        legal   = 1'b1;
        dec.op1 = pc32;
        dec.op2 = {in_instr[31:12], 12'd0};
      end
      default: legal = 1'b0;
    endcase
    dec.illegal = ~legal;
    if (legal) dec.rd = in_instr[11:7];
  end

  // Main/skid pipeline: main feeds the ALU, skid catches a word accepted during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_ready) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        main_q     <= dec;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  // Saturating count of illegal words taken on the input side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (in_fire && dec.illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign in_ready     = ~skid_valid;
  assign out_valid    = main_valid;
  assign out_operand1 = main_q.op1;
  assign out_operand2 = main_q.op2;
  assign out_func3    = main_q.func3;
  assign out_subsra   = main_q.subsra;
  assign out_rd       = main_q.rd;
  assign out_illegal  = main_q.illegal;
  assign illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: expected results pushed at input acceptance,
// popped and compared by an output monitor on every output handshake.
module tb_alu_issue_stage;

  localparam int W = 74;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_operand1;
  logic [31:0] out_operand2;
  logic [2:0]  out_func3;
  logic        out_subsra;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic [15:0] illegal_cnt;

  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  alu_issue_stage #(.CNT_W(16), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_operand1(out_operand1), .out_operand2(out_operand2), .out_func3(out_func3),
    .out_subsra(out_subsra), .out_rd(out_rd), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic [31:0] op1, input logic [31:0] op2,
                                      input logic [2:0] f3, input logic sub,
                                      input logic [4:0] rd, input logic ill);
    return {op1, op2, f3, sub, rd, ill};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver: present one word and wait (bounded) until it is accepted
  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [W-1:0] exp);
    int n;
    @(negedge clk);
    in_instr = instr; in_pc = pc; in_rs1_data = rs1; in_rs2_data = rs2;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: instr 0x%0h never accepted", instr);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(exp);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  // scoreboard monitor: compare each word leaving the stage with the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [W-1:0] act;
      logic [W-1:0] exp;
      act = {out_operand1, out_operand2, out_func3, out_subsra, out_rd, out_illegal};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got 0x%0h expected no word", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL out_word: got 0x%0h expected 0x%0h", act, exp);
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    in_rs1_data = '0; in_rs2_data = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    check("rst_fields", {out_operand1 | out_operand2}, 32'd0);
    check("rst_ctrl", 32'({out_func3, out_subsra, out_rd, out_illegal}), 32'd0);
    rst_n = 1'b1;

    // ADD x3,x1,x2 and one-cycle latency
    send(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(32'd5, 32'd7, 3'b000, 1'b0, 5'd3, 1'b0));
    check("latency_out_valid", 32'(out_valid), 32'd1);
    // SRAI x5,x6,4
    send(32'h40435293, 32'h0, 32'h80000000, 32'h0, mk(32'h80000000, 32'h404, 3'b101, 1'b1, 5'd5, 1'b0));
    // SUB x10,x11,x12
    send(32'h40C58533, 32'h0, 32'd100, 32'd30, mk(32'd100, 32'd30, 3'b000, 1'b1, 5'd10, 1'b0));
    // LUI x7,0x12345 (rs1 data must be ignored)
    send(32'h123453B7, 32'h0, 32'hDEADBEEF, 32'h0, mk(32'h0, 32'h12345000, 3'b000, 1'b0, 5'd7, 1'b0));
    // AUIPC x8,0xABCDE at pc 0x1000
    send(32'hABCDE417, 32'h1000, 32'h5555, 32'h0, mk(32'h1000, 32'hABCDE000, 3'b000, 1'b0, 5'd8, 1'b0));
    // ADDI x1,x2,-1: instr[30]=1 but subsra stays 0 for func3 000
    send(32'hFFF10093, 32'h0, 32'd9, 32'h0, mk(32'd9, 32'hFFFFFFFF, 3'b000, 1'b0, 5'd1, 1'b0));
    // SLLI x4,x4,3
    send(32'h00321213, 32'h0, 32'd2, 32'h0, mk(32'd2, 32'd3, 3'b001, 1'b0, 5'd4, 1'b0));

    // writeback bypass on rs1, then on rs2, then with wb_rd=0
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h99;
`ifdef ISSUE_BYPASS_EN
    send(32'h002081B3, 32'h0, 32'h11, 32'h22, mk(32'h99, 32'h22, 3'b000, 1'b0, 5'd3, 1'b0));
    wb_rd = 5'd2;
    send(32'h002081B3, 32'h0, 32'h11, 32'h22, mk(32'h11, 32'h99, 3'b000, 1'b0, 5'd3, 1'b0));
`else
    send(32'h002081B3, 32'h0, 32'h11, 32'h22, mk(32'h11, 32'h22, 3'b000, 1'b0, 5'd3, 1'b0));
    wb_rd = 5'd2;
    send(32'h002081B3, 32'h0, 32'h11, 32'h22, mk(32'h11, 32'h22, 3'b000, 1'b0, 5'd3, 1'b0));
`endif
    wb_rd = 5'd0;
    send(32'h002081B3, 32'h0, 32'h33, 32'h44, mk(32'h33, 32'h44, 3'b000, 1'b0, 5'd3, 1'b0));
    wb_valid = 1'b0;

    // illegal words
    send(32'hFFFFFFFF, 32'h0, 32'h1, 32'h2, mk(32'h0, 32'h0, 3'b000, 1'b0, 5'd0, 1'b1));
    send(32'h40001033, 32'h0, 32'h1, 32'h2, mk(32'h0, 32'h0, 3'b000, 1'b0, 5'd0, 1'b1));
    check("illegal_cnt_2", 32'(illegal_cnt), 32'd2);
    send(32'h40321213, 32'h0, 32'h1, 32'h2, mk(32'h0, 32'h0, 3'b000, 1'b0, 5'd0, 1'b1));
    check("illegal_cnt_3", 32'(illegal_cnt), 32'd3);

    // stall: two words fill main and skid, in_ready drops, outputs hold
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'h002081B3, 32'h0, 32'hA00, 32'hA01, mk(32'hA00, 32'hA01, 3'b000, 1'b0, 5'd3, 1'b0));
    send(32'h40C58533, 32'h0, 32'hB00, 32'hB01, mk(32'hB00, 32'hB01, 3'b000, 1'b1, 5'd10, 1'b0));
    check("stall_in_ready_low", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_hold_op1", out_operand1, 32'hA00);
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_in_ready_back", 32'(in_ready), 32'd1);
    check("stall_drained", 32'(exp_q.size()), 32'd0);

    // asynchronous reset with a word held at the output
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'h002081B3, 32'h0, 32'hC0, 32'hC1, mk(32'hC0, 32'hC1, 3'b000, 1'b0, 5'd3, 1'b0));
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    check("async_rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;

    // one more word after reset, then drain (bounded)
    send(32'h00321213, 32'h0, 32'd7, 32'h0, mk(32'd7, 32'd3, 3'b001, 1'b0, 5'd4, 1'b0));
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
